// File: rtl/module_packed_assembler_pkg.sv
// Shared types and constants for the byte-to-word assembler.
package module_packed_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HALF = 1'b1
    } asm_state_t;

    localparam int          BYTE_W   = 8;
    localparam int          WORD_W   = 16;
    localparam logic [7:0]  PAD_BYTE = 8'h00;

endpackage

// File: rtl/module_packed_assembler_if.sv
// Byte-in / word-out bus of the assembler; master is the environment side.
interface module_packed_assembler_if
    import module_packed_pkg::*;
#(
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [BYTE_W-1:0] byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              flush;
    logic              consume;
    logic [WORD_W-1:0] word_out;
    logic [BYTE_W-1:0] chk_out;
    logic              word_valid;
    logic [CW-1:0]     count;
    logic              underflow;

    modport master (
        output byte_in, byte_valid, flush, consume,
        input  byte_ready, word_out, chk_out, word_valid, count, underflow
    );

    modport slave (
        input  byte_in, byte_valid, flush, consume,
        output byte_ready, word_out, chk_out, word_valid, count, underflow
    );

endinterface

// File: rtl/module_packed_assembler_fifo.sv
// Small word FIFO with separate count; caller guarantees push only with space, pop only when non-empty.
module pa_word_fifo #(
    parameter int DEPTH  = 2,
    parameter int WORD_W = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [WORD_W-1:0] data_i,
    output logic [WORD_W-1:0] head_o,
    output logic [CW-1:0]     count_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_q, rd_q;
    logic [CW-1:0]     cnt_q;

    assign count_o = cnt_q;
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = empty_o ? '0 : mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= data_i;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + AW'(1);
            if (pop_i)  rd_q <= rd_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/module_packed_assembler.sv
// Pairs stream bytes (low first) into 16-bit words queued in pa_word_fifo.
module module_packed_assembler
    import module_packed_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter bit PAD_EN = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    module_packed_assembler_if.slave  bus
);

    localparam int CW = $clog2(DEPTH + 1);

    asm_state_t        state_q, state_d;
    logic [BYTE_W-1:0] lo_q, lo_d;
    logic              underflow_q, underflow_d;

    logic              push, pop, full, empty, space, hs;
    logic [WORD_W-1:0] push_data, head;
    logic [CW-1:0]     cnt;

    assign pop   = bus.consume && !empty;
    assign space = !full || pop;
    assign bus.byte_ready = (state_q == IDLE) || !full || bus.consume;
    assign hs    = bus.byte_valid && bus.byte_ready;

    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        push        = 1'b0;
        push_data   = {bus.byte_in, lo_q};
        underflow_d = underflow_q | (bus.consume && empty);
        case (state_q)
            IDLE: begin
                if (hs) begin
                    lo_d    = bus.byte_in;
                    state_d = HALF;
                end
            end
            HALF: begin
                // A real second byte wins over a simultaneous flush.
                if (hs) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end else if (bus.flush) begin
                    if (!PAD_EN) begin
                        lo_d    = '0;
                        state_d = IDLE;
                    end else if (space) begin
                        push      = 1'b1;
                        push_data = {PAD_BYTE, lo_q};
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lo_q        <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            underflow_q <= underflow_d;
        end
    end

    pa_word_fifo #(.DEPTH(DEPTH), .WORD_W(WORD_W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (push_data),
        .head_o  (head),
        .count_o (cnt),
        .full_o  (full),
        .empty_o (empty)
    );

    assign bus.word_out   = head;
    assign bus.chk_out    = head[WORD_W-1:BYTE_W] ^ head[BYTE_W-1:0];
    assign bus.word_valid = !empty;
    assign bus.count      = cnt;
    assign bus.underflow  = underflow_q;

endmodule

// File: tb/tb_module_packed_assembler.sv
// Directed bench: PAD_EN=1 instance (a) and PAD_EN=0 instance (b), DEPTH=2.
module tb_module_packed_assembler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    module_packed_assembler_if #(.DEPTH(2)) ba ();
    module_packed_assembler_if #(.DEPTH(2)) bb ();

    module_packed_assembler #(.DEPTH(2), .PAD_EN(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ba)
    );
    module_packed_assembler #(.DEPTH(2), .PAD_EN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bb)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit sel_b, input logic [7:0] b);
        if (sel_b) begin bb.byte_in = b; bb.byte_valid = 1'b1; end
        else       begin ba.byte_in = b; ba.byte_valid = 1'b1; end
        tick();
        ba.byte_valid = 1'b0;
        bb.byte_valid = 1'b0;
    endtask

    task automatic drain_a();
        ba.consume = 1'b1;
        tick();
        tick();
        ba.consume = 1'b0;
    endtask

    initial begin
        ba.byte_in = '0; ba.byte_valid = 1'b0; ba.flush = 1'b0; ba.consume = 1'b0;
        bb.byte_in = '0; bb.byte_valid = 1'b0; bb.flush = 1'b0; bb.consume = 1'b0;
        #12;
        chk("rst_word",  ba.word_out,   32'h0);
        chk("rst_chk",   ba.chk_out,    32'h0);
        chk("rst_valid", ba.word_valid, 32'h0);
        chk("rst_count", ba.count,      32'h0);
        chk("rst_unf",   ba.underflow,  32'h0);
        chk("rst_ready", ba.byte_ready, 32'h1);
        rst_n = 1'b1;
        tick();

        // pair assembly
        send(1'b0, 8'h34);
        chk("half_valid", ba.word_valid, 32'h0);
        send(1'b0, 8'h12);
        chk("pair_word",  ba.word_out,   32'h1234);
        chk("pair_chk",   ba.chk_out,    32'h26);
        chk("pair_valid", ba.word_valid, 32'h1);
        chk("pair_count", ba.count,      32'h1);
        ba.consume = 1'b1;
        tick();
        ba.consume = 1'b0;
        chk("pop_count", ba.count,      32'h0);
        chk("pop_valid", ba.word_valid, 32'h0);

        // fill and backpressure
        send(1'b0, 8'h01); send(1'b0, 8'h02);
        send(1'b0, 8'h03); send(1'b0, 8'h04);
        chk("full_count", ba.count, 32'h2);
        send(1'b0, 8'h05);
        ba.byte_in = 8'h06; ba.byte_valid = 1'b1;
        #1;
        chk("stall_ready", ba.byte_ready, 32'h0);
        tick();
        chk("stall_head",  ba.word_out, 32'h0201);
        chk("stall_count", ba.count,    32'h2);
        ba.consume = 1'b1;
        #1;
        chk("cons_ready", ba.byte_ready, 32'h1);
        tick();
        ba.consume = 1'b0; ba.byte_valid = 1'b0;
        chk("pp_count", ba.count,    32'h2);
        chk("pp_head",  ba.word_out, 32'h0403);
        ba.consume = 1'b1;
        tick();
        ba.consume = 1'b0;
        chk("tail_word", ba.word_out, 32'h0605);
        ba.consume = 1'b1;
        tick();
        ba.consume = 1'b0;
        chk("drain_count", ba.count, 32'h0);

        // flush with pad
        send(1'b0, 8'hAB);
        ba.flush = 1'b1;
        tick();
        ba.flush = 1'b0;
        chk("pad_word",  ba.word_out, 32'h00AB);
        chk("pad_chk",   ba.chk_out,  32'hAB);
        chk("pad_count", ba.count,    32'h1);
        drain_a();

        // flush without pad: drop, then a fresh pair proves state went IDLE
        send(1'b1, 8'hAB);
        bb.flush = 1'b1;
        tick();
        bb.flush = 1'b0;
        chk("drop_count", bb.count, 32'h0);
        send(1'b1, 8'h55);
        send(1'b1, 8'h66);
        chk("drop_next", bb.word_out, 32'h6655);
        chk("drop_ncnt", bb.count,    32'h1);

        // flush and byte in the same cycle
        send(1'b0, 8'h11);
        ba.flush = 1'b1;
        send(1'b0, 8'h22);
        ba.flush = 1'b0;
        chk("coll_word",  ba.word_out, 32'h2211);
        chk("coll_count", ba.count,    32'h1);
        tick();
        chk("coll_nopad", ba.count, 32'h1);
        drain_a();

        // underflow
        ba.consume = 1'b1;
        tick();
        ba.consume = 1'b0;
        chk("unf_set",   ba.underflow, 32'h1);
        chk("unf_count", ba.count,     32'h0);
        tick(); tick();
        chk("unf_hold", ba.underflow, 32'h1);

        // async reset mid-pair with a word held
        send(1'b0, 8'h77); send(1'b0, 8'h88);
        send(1'b0, 8'h99);
        chk("pre_count", ba.count, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_word",  ba.word_out,   32'h0);
        chk("ar_valid", ba.word_valid, 32'h0);
        chk("ar_count", ba.count,      32'h0);
        chk("ar_unf",   ba.underflow,  32'h0);
        chk("ar_chk",   ba.chk_out,    32'h0);
        rst_n = 1'b1;
        tick();
        send(1'b0, 8'hC3);
        send(1'b0, 8'h5A);
        chk("fresh_word",  ba.word_out, 32'h5AC3);
        chk("fresh_count", ba.count,    32'h1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
